// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N shift-add multiplier, one partial
// product per clock, built around an internal ripple-carry adder.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   multiplicand          operand A, unsigned, N bits
//   multiplier            operand B, unsigned, N bits
//   out_valid / out_ready product handshake (out_valid high only in DONE)
//   product               A*B, 2N bits, held until the next result or reset
//   busy                  high while partial products are being summed

module ripple_carry_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    always_comb begin
        logic carry;
        sum   = '0;
        carry = cin;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module shift_add_multiplier #(
    parameter  int N     = 16,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [N-1:0]     add_b;
    logic [N-1:0]     add_sum;
    logic             add_cout;
    logic [2*N-1:0]   acc_step;

    // High half of the accumulator plus the multiplicand when the
    // current multiplier bit (acc LSB) is set.
    assign add_b = acc_q[0] ? mcand_q : '0;

    ripple_carry_adder #(
        .W (N)
    ) u_adder (
        .a    (acc_q[2*N-1:N]),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The N+1 bit sum lands in the top, the consumed multiplier bit
    // falls off the bottom.
    assign acc_step = {add_cout, add_sum, acc_q[N-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = multiplicand;
                    acc_d   = {{N{1'b0}}, multiplier};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    product_d = acc_step;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign product   = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (N=16): vector table,
// backpressure, mid-run reset and random ops against a queue scoreboard.

module tb_shift_add_multiplier;

    localparam int N = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  multiplicand;
    logic [N-1:0]  multiplier;
    logic          out_valid;
    logic          out_ready;
    logic [2*N-1:0] product;
    logic          busy;

    int tests;
    int fails;
    logic [2*N-1:0] exp_q[$];

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } vec_t;

    vec_t vecs[8];

    shift_add_multiplier #(
        .N (N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp, input bit stall);
        int n;
        logic [2*N-1:0] want;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        if (!in_ready) return;
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        exp_q.push_back(exp);
        tick();
        in_valid     = 1'b0;
        multiplicand = N'($urandom);
        multiplier   = N'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            if (n == 8) begin
                chk("busy_run", {62'd0, busy, in_ready}, 64'b10);
            end
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(N));
        if (!out_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        out_ready = 1'b0;
        if (stall) begin
            n = 0;
            while ($urandom_range(0, 1) == 1 && n < 8) begin
                tick();
                n++;
            end
            chk("stall_hold", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            want = exp_q.pop_front();
            chk("product", 64'(product), 64'(want));
        end
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int n;
        bit ok;

        tests = 0;
        fails = 0;
        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h1234, 16'h0000, 32'h00000000};
        vecs[3] = '{16'h0000, 16'hABCD, 32'h00000000};
        vecs[4] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
        vecs[5] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[7] = '{16'hABCD, 16'h1234, 32'h0C374FA4};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_product",   64'(product),   64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0);
        end

        // Backpressure: hold result for 10 cycles, new operands ignored.
        multiplicand = 16'h0003;
        multiplier   = 16'h0007;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("bp_latency", 64'(n), 64'(N));
        multiplicand = 16'hFFFF;
        multiplier   = 16'hFFFF;
        in_valid     = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid || in_ready || product !== 32'h15) ok = 1'b0;
            tick();
        end
        chk("bp_hold", 64'(ok), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {61'd0, out_valid, in_ready, busy}, 64'b010);
        chk("bp_product_kept", 64'(product), 64'h15);

        // Reset during RUN discards the operation.
        multiplicand = 16'h00FF;
        multiplier   = 16'h0101;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_state", {61'd0, in_ready, out_valid, busy}, 64'b100);
        chk("mid_rst_product", 64'(product), 64'd0);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || busy) ok = 1'b0;
            tick();
        end
        chk("mid_rst_quiet", 64'(ok), 64'd1);
        run_op(16'h00FF, 16'h0101, 32'h0000FFFF, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            run_op(ra, rb, 32'(ra) * 32'(rb), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
